// File: rtl/pipeline_sched.sv
// Pipeline sequencer: drives PC and pipeline-register enables/flushes and runs the RUN/PAUSED/STEP/HALTED flow.
// Optional macro STAT_COUNTERS_EN builds the stall/flush/frozen statistic counters; without it they read 0.
module pipeline_sched #(
    parameter logic [31:0] HALT_CODE  = 32'h0000_000A,
    parameter logic [31:0] PAUSE_CODE = 32'h0000_0032,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             syscall_wb,
    input  logic [31:0]      a_wb,
    input  logic             resume,
    input  logic             step,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] frozen_cnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_PAUSED = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t state_q;
    logic   skip_q;
    logic   det_halt;
    logic   det_pause;
    logic   freeze;
    logic   advance;

    // skip masks the syscall still parked in WB on the first cycle after leaving PAUSED
    assign det_halt  = syscall_wb & ~skip_q & (a_wb == HALT_CODE);
    assign det_pause = syscall_wb & ~skip_q & (a_wb == PAUSE_CODE);
    assign freeze    = det_halt | det_pause;
    assign advance   = ((state_q == S_RUN) & ~freeze) | (state_q == S_STEP);
    assign state     = state_q;

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if (advance) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            skip_q  <= 1'b0;
        end else begin
            if (advance)
                skip_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (det_halt)
                        state_q <= S_HALTED;
                    else if (det_pause)
                        state_q <= S_PAUSED;
                end
                S_PAUSED: begin
                    if (syscall_wb && (a_wb == HALT_CODE)) begin
                        state_q <= S_HALTED;
                    end else if (resume) begin
                        state_q <= S_RUN;
                        skip_q  <= 1'b1;
                    end else if (step) begin
                        state_q <= S_STEP;
                        skip_q  <= 1'b1;
                    end
                end
                S_STEP:   state_q <= S_PAUSED;
                default:  state_q <= S_HALTED;
            endcase
        end
    end

`ifdef STAT_COUNTERS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] frozen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            flush_q  <= '0;
            frozen_q <= '0;
        end else begin
            if (advance && load_use && !branch_taken)
                stall_q <= stall_q + CNT_ONE;
            if (advance && branch_taken)
                flush_q <= flush_q + CNT_ONE;
            if ((state_q == S_PAUSED) || (state_q == S_HALTED))
                frozen_q <= frozen_q + CNT_ONE;
        end
    end

    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign frozen_cnt = frozen_q;
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign frozen_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_sched.sv
// Directed bench for pipeline_sched: expected per-cycle outputs are queued at drive time and checked at the negedge.
module tb_pipeline_sched;

`ifdef STAT_COUNTERS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
    localparam logic [6:0] EA = 7'b1101011;
    localparam logic [6:0] EN = 7'b0000000;
    localparam logic [6:0] EL = 7'b0001111;
    localparam logic [6:0] EB = 7'b1111111;
    localparam logic [31:0] PC = 32'h0000_0032;
    localparam logic [31:0] HC = 32'h0000_000A;

    logic        clk = 1'b0;
    logic        rst, load_use, branch_taken, syscall_wb, resume, step;
    logic [31:0] a_wb;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt, frozen_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  en;
        logic [31:0] st;
        logic [31:0] stall;
        logic [31:0] flush;
        logic [31:0] frozen;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipeline_sched #(
        .HALT_CODE (32'h0000_000A),
        .PAUSE_CODE(32'h0000_0032),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_use    (load_use),
        .branch_taken(branch_taken),
        .syscall_wb  (syscall_wb),
        .a_wb        (a_wb),
        .resume      (resume),
        .step        (step),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .if_id_flush (if_id_flush),
        .id_ex_en    (id_ex_en),
        .id_ex_flush (id_ex_flush),
        .ex_mem_en   (ex_mem_en),
        .mem_wb_en   (mem_wb_en),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .frozen_cnt  (frozen_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, queue the expectation, compare at the negedge, then advance past the posedge.
    task automatic cyc(input int lu, input int br, input int sc, input logic [31:0] a,
                       input int res, input int stp, input int rs,
                       input logic [6:0] ev, input int es, input int ss, input int fs, input int zs);
        exp_t e;
        exp_t g;
        rst          = (rs  != 0);
        load_use     = (lu  != 0);
        branch_taken = (br  != 0);
        syscall_wb   = (sc  != 0);
        a_wb         = a;
        resume       = (res != 0);
        step         = (stp != 0);
        e.en     = ev;
        e.st     = 32'(es);
        e.stall  = STATS ? 32'(ss) : 32'd0;
        e.flush  = STATS ? 32'(fs) : 32'd0;
        e.frozen = STATS ? 32'(zs) : 32'd0;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        chk("enables", {25'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en},
            {25'd0, g.en});
        chk("state", {30'd0, state}, g.st);
        chk("stall_cnt", stall_cnt, g.stall);
        chk("flush_cnt", flush_cnt, g.flush);
        chk("frozen_cnt", frozen_cnt, g.frozen);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; load_use = 1'b0; branch_taken = 1'b0; syscall_wb = 1'b0;
        a_wb = '0; resume = 1'b0; step = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state and idle RUN
        for (int i = 0; i < 5; i++) cyc(0,0,0,32'd0, 0,0,0, EA,0, 0,0,0);

        // Load-use bubble twice
        cyc(1,0,0,32'd0, 0,0,0, EL,0, 0,0,0);
        cyc(1,0,0,32'd0, 0,0,0, EL,0, 1,0,0);
        cyc(0,0,0,32'd0, 0,0,0, EA,0, 2,0,0);

        // Branch beats load-use
        cyc(1,1,0,32'd0, 0,0,0, EB,0, 2,0,0);
        cyc(0,0,0,32'd0, 0,0,0, EA,0, 2,1,0);

        // Pause syscall: freeze, then PAUSED for 4 cycles
        cyc(0,0,1,PC, 0,0,0, EN,0, 2,1,0);
        for (int i = 0; i < 4; i++) cyc(0,0,1,PC, 0,0,0, EN,1, 2,1,i);
        cyc(0,0,1,PC, 0,1,0, EN,1, 2,1,4);
        cyc(0,0,1,PC, 0,0,0, EA,2, 2,1,5);

        // resume and step together: resume wins, one masked cycle, then re-detection
        cyc(0,0,1,PC, 1,1,0, EN,1, 2,1,5);
        cyc(0,0,1,PC, 0,0,0, EA,0, 2,1,6);
        cyc(0,0,1,PC, 0,0,0, EN,0, 2,1,6);
        cyc(0,0,0,32'd0, 1,0,0, EN,1, 2,1,6);
        cyc(0,0,0,32'd0, 0,0,0, EA,0, 2,1,7);

        // Halt syscall: terminal until reset
        cyc(0,0,1,HC, 0,0,0, EN,0, 2,1,7);
        for (int i = 0; i < 10; i++) cyc(1,0,0,32'd0, i % 2, 1 - (i % 2), 0, EN,3, 2,1,7+i);
        cyc(0,0,0,32'd0, 0,0,1, EN,3, 2,1,17);
        cyc(0,0,0,32'd0, 0,0,0, EA,0, 0,0,0);
        cyc(1,0,0,32'd0, 0,0,0, EL,0, 0,0,0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
